fix_tokenizer: RTL

- Upstream stage of the FIX tag/value extractor.
- Takes the raw FIX byte stream, one byte per valid cycle, and classifies each byte as tag, '=', value, or SOH (0x01).
- Drives `data_o`, `start_tag_o` and `start_value_o` as level strobes for the extractor.
- Also computes the FIX CheckSum (tag 10), checks it against the received field, and flags framing errors.

---
 rtl/fix_tokenizer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/fix_tokenizer.sv
// fix_tokenizer: classifies a raw FIX byte stream into tag / '=' / value / SOH,
// forwards each accepted byte one cycle later with tag/value level strobes,
// computes the FIX CheckSum (tag 10) and flags framing errors.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | between messages; next valid byte starts a new message as a tag
// TAG    | collecting tag digits up to '='
// VALUE  | collecting value bytes up to SOH
// RESYNC | framing error seen; forward bytes silently until the next SOH
module fix_tokenizer #(
    parameter int MAX_TAG_LEN   = 4,
    parameter int MAX_VALUE_LEN = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       start_tag_o,
    output logic       start_value_o,
    output logic [7:0] checksum_o,
    output logic       checksum_valid_o,
    output logic       checksum_ok_o,
    output logic       format_err_o
);

    localparam int TCW = $clog2(MAX_TAG_LEN + 1);
    localparam int VCW = $clog2(MAX_VALUE_LEN + 1);
    localparam logic [TCW-1:0] TAG_MAX = TCW'(MAX_TAG_LEN);
    localparam logic [VCW-1:0] VAL_MAX = VCW'(MAX_VALUE_LEN);
    localparam logic [VCW-1:0] CHK_DIGITS = VCW'(3);
    localparam logic [7:0] SOH = 8'h01;
    localparam logic [7:0] EQ  = 8'h3D;

    typedef enum logic [1:0] {IDLE, TAG, VALUE, RESYNC} state_t;

    state_t          state;
    state_t          cur_state;
    logic [7:0]      sum;
    logic [7:0]      sum_cur;
    logic [7:0]      tag_base;
    logic [TCW-1:0]  tag_cnt;
    logic [TCW-1:0]  tag_cnt_cur;
    logic [VCW-1:0]  val_cnt;
    logic            tag_is10;
    logic            chk_field;
    logic            chk_field_cur;
    logic            chk_digits;
    logic [9:0]      chk_val;
    logic            is_digit;
    logic            is_eq;
    logic            is_soh;

    // Byte classification and the "IDLE behaves as a freshly cleared TAG" view
    always_comb begin
        is_digit      = (data_i >= 8'h30) && (data_i <= 8'h39);
        is_eq         = (data_i == EQ);
        is_soh        = (data_i == SOH);
        cur_state     = (state == IDLE) ? TAG : state;
        sum_cur       = (state == IDLE) ? 8'h00 : sum;
        tag_cnt_cur   = (state == IDLE) ? '0 : tag_cnt;
        chk_field_cur = (state == IDLE) ? 1'b0 : chk_field;
    end

    // Tokenizer FSM with registered outputs; idle cycles leave state untouched
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            sum              <= '0;
            tag_base         <= '0;
            tag_cnt          <= '0;
            val_cnt          <= '0;
            tag_is10         <= 1'b0;
            chk_field        <= 1'b0;
            chk_digits       <= 1'b0;
            chk_val          <= '0;
            data_o           <= '0;
            valid_o          <= 1'b0;
            start_tag_o      <= 1'b0;
            start_value_o    <= 1'b0;
            checksum_o       <= '0;
            checksum_valid_o <= 1'b0;
            checksum_ok_o    <= 1'b0;
            format_err_o     <= 1'b0;
        end else begin
            valid_o          <= 1'b0;
            checksum_valid_o <= 1'b0;
            checksum_ok_o    <= 1'b0;
            format_err_o     <= 1'b0;
            if (valid_i) begin
                valid_o   <= 1'b1;
                data_o    <= data_i;
                sum       <= sum_cur + data_i;
                chk_field <= chk_field_cur;
                case (cur_state)
                    TAG: begin
                        if (is_digit && (tag_cnt_cur < TAG_MAX)) begin
                            state         <= TAG;
                            start_tag_o   <= 1'b1;
                            start_value_o <= 1'b0;
                            tag_cnt       <= tag_cnt_cur + 1'b1;
                            if (tag_cnt_cur == '0) begin
                                // snapshot excludes this tag's own bytes
                                tag_base <= sum_cur;
                                tag_is10 <= (data_i == 8'h31);
                            end else begin
                                tag_is10 <= tag_is10 && (tag_cnt_cur == TCW'(1))
                                            && (data_i == 8'h30);
                            end
                        end else if (is_eq && (tag_cnt_cur != '0)) begin
                            state         <= VALUE;
                            start_tag_o   <= 1'b0;
                            start_value_o <= 1'b0;
                            val_cnt       <= '0;
                            chk_val       <= '0;
                            chk_digits    <= 1'b1;
                            if ((tag_cnt_cur == TCW'(2)) && tag_is10) begin
                                chk_field  <= 1'b1;
                                checksum_o <= tag_base;
                            end
                        end else begin
                            state         <= RESYNC;
                            start_tag_o   <= 1'b0;
                            start_value_o <= 1'b0;
                            format_err_o  <= 1'b1;
                        end
                    end
                    VALUE: begin
                        if (is_soh) begin
                            start_tag_o   <= 1'b0;
                            start_value_o <= 1'b0;
                            if (val_cnt != '0) begin
                                if (chk_field) begin
                                    checksum_valid_o <= 1'b1;
                                    checksum_ok_o    <= (val_cnt == CHK_DIGITS) && chk_digits
                                                        && (chk_val == {2'b00, checksum_o});
                                    state            <= IDLE;
                                end else begin
                                    state   <= TAG;
                                    tag_cnt <= '0;
                                end
                            end else begin
                                state        <= RESYNC;
                                format_err_o <= 1'b1;
                            end
                        end else if (val_cnt == VAL_MAX) begin
                            state         <= RESYNC;
                            start_tag_o   <= 1'b0;
                            start_value_o <= 1'b0;
                            format_err_o  <= 1'b1;
                        end else begin
                            start_tag_o   <= 1'b0;
                            start_value_o <= 1'b1;
                            val_cnt       <= val_cnt + 1'b1;
                            if (chk_field) begin
                                chk_val    <= (chk_val * 10'd10) + {6'd0, data_i[3:0]};
                                chk_digits <= chk_digits && is_digit;
                            end
                        end
                    end
                    RESYNC: begin
                        start_tag_o   <= 1'b0;
                        start_value_o <= 1'b0;
                        if (is_soh) begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
